snake_game_ctrl: RTL and testbench

- Top-level game sequencer for the snake game.
- Runs the IDLE/PLAY/PAUSE/OVER/WIN state machine and owns the `points` count fed to the scoreboard.
- Generates the snake movement tick, which speeds up as points rise, and a clear pulse that resets the scoreboard at the start of each game.
- Sits between the button inputs, the collision controller (`eat`/`crash` pulses), the scoreboard and the snake-movement logic.

---
 rtl/snake_pkg.sv | 18 +
 rtl/snake_move_tick.sv | 40 ++++
 rtl/snake_game_ctrl.sv | 113 +++++++++++
 tb/tb_snake_game_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake game blocks.
//   game_state_t  : encoded game FSM state (IDLE=0 .. WIN=4)
//   POINTS_W      : width of the score bus shared with the scoreboard
//   DEF_MAX_SCORE : default winning score, shared with the scoreboard
package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_OVER  = 3'd3,
        ST_WIN   = 3'd4
    } game_state_t;

    localparam int POINTS_W      = 6;
    localparam int DEF_MAX_SCORE = 16;

endpackage

// File: rtl/snake_move_tick.sv
// snake_move_tick: programmable-period tick generator for snake movement.
//   clk, rst (async, active-low)
//   enable : count this cycle; counter holds when low
//   clear  : restart the count from zero (wins over enable)
//   period : tick period in clk cycles (>= 2)
//   tick   : one-cycle pulse each time the count reaches period-1
module snake_move_tick #(
    parameter int CNT_W = 25,
    parameter int PER_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             fire;

    // >= rather than == so a period that shrinks below the current count fires at once
    assign fire = PER_W'(cnt) >= period - PER_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            tick <= fire;
            cnt  <= fire ? '0 : cnt + CNT_W'(1);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer (IDLE/PLAY/PAUSE/OVER/WIN), score keeping and move tick.
//   clk, rst (async, active-low)
//   start_btn, pause_btn : debounced button levels
//   eat, crash           : one-cycle pulses from the collision controller
//   points, high_score   : current and best score
//   game_state           : encoded FSM state
//   move_tick            : one-cycle pulse, advance snake
//   score_clear          : one-cycle pulse at game start, clears the scoreboard
//   game_over, win       : high while in OVER / WIN
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_SCORE = DEF_MAX_SCORE,
    parameter int TICK_BASE = 25000000,
    parameter int TICK_STEP = 1000000,
    parameter int TICK_MIN  = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_btn,
    input  logic                pause_btn,
    input  logic                eat,
    input  logic                crash,
    output logic [POINTS_W-1:0] points,
    output logic [POINTS_W-1:0] high_score,
    output logic [2:0]          game_state,
    output logic                move_tick,
    output logic                score_clear,
    output logic                game_over,
    output logic                win
);

    localparam int CNT_W = $clog2(TICK_BASE);
    localparam int PER_W = $clog2(TICK_BASE + 1);
    localparam logic [POINTS_W-1:0] MAX_P = POINTS_W'(MAX_SCORE);

    game_state_t         state, next;
    logic                start_q, pause_q, start_edge, pause_edge;
    logic                clear;
    logic [POINTS_W-1:0] points_next;
    logic [31:0]         drop;
    logic [PER_W-1:0]    period;

    assign start_edge = start_btn & ~start_q;
    assign pause_edge = pause_btn & ~pause_q;
    assign game_state = state;

    // compare before subtracting so a large score cannot underflow the period
    assign drop   = 32'(points) * 32'(TICK_STEP);
    assign period = (drop >= 32'(TICK_BASE - TICK_MIN)) ? PER_W'(TICK_MIN)
                                                         : PER_W'(32'(TICK_BASE) - drop);

    always_comb begin
        next        = state;
        points_next = points;
        clear       = 1'b0;
        case (state)
            ST_IDLE: if (start_edge) begin
                next        = ST_PLAY;
                points_next = '0;
                clear       = 1'b1;
            end
            ST_PLAY: if (crash) begin
                next = ST_OVER;
            end else begin
                if (eat) points_next = (points >= MAX_P) ? MAX_P : points + POINTS_W'(1);
                if (eat && points_next == MAX_P) next = ST_WIN;
                else if (pause_edge)             next = ST_PAUSE;
            end
            ST_PAUSE: if (pause_edge) next = ST_PLAY;
            ST_OVER, ST_WIN: if (start_edge) next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            points      <= '0;
            high_score  <= '0;
            score_clear <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
        end else begin
            state       <= next;
            start_q     <= start_btn;
            pause_q     <= pause_btn;
            points      <= points_next;
            score_clear <= clear;
            game_over   <= (next == ST_OVER);
            win         <= (next == ST_WIN);
            if (state == ST_PLAY && (next == ST_OVER || next == ST_WIN) && points_next > high_score)
                high_score <= points_next;
        end
    end

    // counting only while PLAY continues keeps the last PLAY cycle from leaking a tick
    // into OVER/WIN/PAUSE, and leaves the count frozen across a pause
    snake_move_tick #(
        .CNT_W (CNT_W),
        .PER_W (PER_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state == ST_PLAY && next == ST_PLAY),
        .clear  (clear),
        .period (period),
        .tick   (move_tick)
    );

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed scenarios plus random play checked against a behavioural game model.
module tb_snake_game_ctrl;

    localparam int MS = 4;
    localparam int TB = 10;
    localparam int TS = 2;
    localparam int TM = 4;

    logic       clk, rst, start_btn, pause_btn, eat, crash;
    logic [5:0] points, high_score;
    logic [2:0] game_state;
    logic       move_tick, score_clear, game_over, win;

    snake_game_ctrl #(
        .MAX_SCORE (MS),
        .TICK_BASE (TB),
        .TICK_STEP (TS),
        .TICK_MIN  (TM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .eat         (eat),
        .crash       (crash),
        .points      (points),
        .high_score  (high_score),
        .game_state  (game_state),
        .move_tick   (move_tick),
        .score_clear (score_clear),
        .game_over   (game_over),
        .win         (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural game model: 0 idle, 1 play, 2 pause, 3 over, 4 win
    int m_state, m_points, m_high, m_elapsed;
    int m_tick, m_clear;
    bit m_sq, m_pq;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tick_period(input int p);
        int r;
        r = TB - p * TS;
        return (r < TM) ? TM : r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_points = 0; m_high = 0; m_elapsed = 0;
        m_tick = 0; m_clear = 0; m_sq = 0; m_pq = 0;
    endtask

    // one clock edge of the game rules, using the inputs held across that edge
    task automatic model_step();
        bit se, pe;
        int per;
        se = start_btn && !m_sq;
        pe = pause_btn && !m_pq;
        m_tick = 0;
        m_clear = 0;
        per = tick_period(m_points);
        case (m_state)
            0: if (se) begin
                m_state = 1; m_points = 0; m_elapsed = 0; m_clear = 1;
            end
            1: begin
                if (crash) m_state = 3;
                else begin
                    if (eat) m_points = (m_points + 1 > MS) ? MS : m_points + 1;
                    if (eat && m_points == MS) m_state = 4;
                    else if (pe) m_state = 2;
                end
                if (m_state == 1) begin
                    m_elapsed++;
                    if (m_elapsed >= per) begin
                        m_tick = 1;
                        m_elapsed = 0;
                    end
                end
                if ((m_state == 3 || m_state == 4) && m_points > m_high) m_high = m_points;
            end
            2: if (pe) m_state = 1;
            default: if (se) m_state = 0;
        endcase
        m_sq = start_btn;
        m_pq = pause_btn;
    endtask

    task automatic compare_all();
        check("state", int'(game_state), m_state);
        check("points", int'(points), m_points);
        check("high_score", int'(high_score), m_high);
        check("move_tick", int'(move_tick), m_tick);
        check("score_clear", int'(score_clear), m_clear);
        check("game_over", int'(game_over), int'(m_state == 3));
        check("win", int'(win), int'(m_state == 4));
    endtask

    task automatic cyc(input logic s, input logic p, input logic e, input logic c);
        start_btn = s; pause_btn = p; eat = e; crash = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // cycles from now until the next observed move_tick; -1 if none within the budget
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 0, 0, 0);
            if (move_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic new_game();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        if (game_state != 3'd1) begin
            cyc(0, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
    endtask

    initial begin
        int n, ticks;
        rst = 1'b0; start_btn = 0; pause_btn = 0; eat = 0; crash = 0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b1;

        // game 1: start, tick cadence, pause, then eat+crash at 2 points
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("start_clear", int'(score_clear), 1);
        check("start_state", int'(game_state), 1);
        check("start_points", int'(points), 0);
        cyc(0, 0, 0, 0);
        check("clear_one_cycle", int'(score_clear), 0);
        wait_tick(n);
        check("first_tick", n + 1, 10);
        wait_tick(n);
        check("tick_period0", n, 10);
        repeat (6) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("paused", int'(game_state), 2);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(0, 1, (i == 10 || i == 30), (i == 20));
            ticks += int'(move_tick);
        end
        check("pause_no_ticks", ticks, 0);
        check("pause_eat_ignored", int'(points), 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("resumed", int'(game_state), 1);
        cyc(0, 0, 0, 0);
        wait_tick(n);
        check("resume_tick", n + 1, 4);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        check("crash_state", int'(game_state), 3);
        check("crash_points", int'(points), 2);
        check("crash_over", int'(game_over), 1);
        check("crash_high", int'(high_score), 2);
        check("crash_no_tick", int'(move_tick), 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("over_to_idle", int'(game_state), 0);
        check("idle_keeps_points", int'(points), 2);

        // game 2: speed-up to the clamped period, then win
        new_game();
        check("g2_points", int'(points), 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("three_eats", int'(points), 3);
        wait_tick(n);
        wait_tick(n);
        check("tick_period3", n, 4);
        cyc(0, 0, 1, 0);
        check("win_state", int'(game_state), 4);
        check("win_flag", int'(win), 1);
        check("win_points", int'(points), 4);
        check("win_high", int'(high_score), 4);
        cyc(0, 0, 1, 0);
        check("win_eat_ignored", int'(points), 4);

        // game 3: low score leaves high_score alone
        new_game();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        check("g3_over", int'(game_state), 3);
        check("g3_high", int'(high_score), 4);

        // game 4: asynchronous reset in the middle of play
        new_game();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("g4_points", int'(points), 3);
        #2 rst = 1'b0;
        #1;
        check("arst_state", int'(game_state), 0);
        check("arst_points", int'(points), 0);
        check("arst_high", int'(high_score), 0);
        check("arst_tick", int'(move_tick), 0);
        check("arst_clear", int'(score_clear), 0);
        check("arst_over", int'(game_over), 0);
        check("arst_win", int'(win), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // random play
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
